// File: rtl/acc_core.sv
// ---------------------------------------------------------------------------
// acc_core -- fetch/execute sequencer for the small processor.
//
// Drives the ROM address from the program counter, registers the returned
// 17-bit instruction word {op[16:15], imm[14:0]} and executes it against a
// signed, wrapping accumulator. OUT results leave on a valid/ready port.
//
// Ports
//   clk        system clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   start      begin execution (honoured only in IDLE or HALT)
//   rom_addr   ROM address, always equal to pc
//   rom_data   combinational ROM word {op, imm}
//   out_data   accumulator value emitted by OUT
//   out_tag    imm[3:0] of the OUT instruction
//   out_valid  out_data/out_tag valid
//   out_ready  consumer accepts when high together with out_valid
//   acc        current accumulator (observe)
//   busy       high in FETCH, EXEC and OUT_WAIT
//   halted     high in HALT
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | after reset, waiting for start
// FETCH    | latch rom_data at pc into ir
// EXEC     | apply the latched instruction
// OUT_WAIT | result presented, waiting for out_ready
// HALT     | self-jump seen, waiting for start to restart from 0
// ---------------------------------------------------------------------------
module acc_core #(
    parameter int ACC_W = 16,
    parameter int PC_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [PC_W-1:0]  rom_addr,
    input  logic [16:0]      rom_data,
    output logic [ACC_W-1:0] out_data,
    output logic [3:0]       out_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic             busy,
    output logic             halted
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_FETCH    = 3'd1,
        S_EXEC     = 3'd2,
        S_OUT_WAIT = 3'd3,
        S_HALT     = 3'd4
    } state_t;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_JMP = 2'd1;
    localparam logic [1:0] OP_BNZ = 2'd2;
    localparam logic [1:0] OP_OUT = 2'd3;

    state_t             r_state;
    logic [PC_W-1:0]    r_pc;
    logic [ACC_W-1:0]   r_acc;
    logic [16:0]        r_ir;
    logic [ACC_W-1:0]   r_out_data;
    logic [3:0]         r_out_tag;
    logic               r_out_valid;

    state_t             w_state_nxt;
    logic [PC_W-1:0]    w_pc_nxt;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [16:0]        w_ir_nxt;
    logic [ACC_W-1:0]   w_out_data_nxt;
    logic [3:0]         w_out_tag_nxt;
    logic               w_out_valid_nxt;

    logic [1:0]         w_op;
    logic [14:0]        w_imm;
    logic [ACC_W-1:0]   w_imm_sext;
    logic [PC_W-1:0]    w_target;
    logic [PC_W-1:0]    w_pc_inc;

    assign w_op       = r_ir[16:15];
    assign w_imm      = r_ir[14:0];
    // Signed cast before resizing replicates imm[14] into the upper bits.
    assign w_imm_sext = ACC_W'($signed(w_imm));
    assign w_target   = w_imm[PC_W-1:0];
    assign w_pc_inc   = r_pc + PC_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_pc        <= '0;
            r_acc       <= '0;
            r_ir        <= '0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_pc        <= w_pc_nxt;
            r_acc       <= w_acc_nxt;
            r_ir        <= w_ir_nxt;
            r_out_data  <= w_out_data_nxt;
            r_out_tag   <= w_out_tag_nxt;
            r_out_valid <= w_out_valid_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_pc_nxt        = r_pc;
        w_acc_nxt       = r_acc;
        w_ir_nxt        = r_ir;
        w_out_data_nxt  = r_out_data;
        w_out_tag_nxt   = r_out_tag;
        w_out_valid_nxt = r_out_valid;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_FETCH;
                end
            end

            S_FETCH: begin
                w_ir_nxt    = rom_data;
                w_state_nxt = S_EXEC;
            end

            S_EXEC: begin
                w_state_nxt = S_FETCH;
                unique case (w_op)
                    OP_ADD: begin
                        w_acc_nxt = r_acc + w_imm_sext;
                        w_pc_nxt  = w_pc_inc;
                    end
                    OP_JMP: begin
                        // A jump to itself can never make progress: park in HALT.
                        if (w_target == r_pc) begin
                            w_state_nxt = S_HALT;
                        end else begin
                            w_pc_nxt = w_target;
                        end
                    end
                    OP_BNZ: begin
                        w_pc_nxt = (r_acc != '0) ? w_target : w_pc_inc;
                    end
                    OP_OUT: begin
                        // pc advances only once the consumer takes the result.
                        w_out_data_nxt  = r_acc;
                        w_out_tag_nxt   = w_imm[3:0];
                        w_out_valid_nxt = 1'b1;
                        w_state_nxt     = S_OUT_WAIT;
                    end
                    default: ;
                endcase
            end

            S_OUT_WAIT: begin
                if (out_ready) begin
                    w_out_valid_nxt = 1'b0;
                    w_pc_nxt        = w_pc_inc;
                    w_state_nxt     = S_FETCH;
                end
            end

            S_HALT: begin
                if (start) begin
                    w_pc_nxt    = '0;
                    w_acc_nxt   = '0;
                    w_state_nxt = S_FETCH;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign rom_addr  = r_pc;
    assign acc       = r_acc;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;
    assign out_valid = r_out_valid;
    assign busy      = (r_state == S_FETCH) || (r_state == S_EXEC) || (r_state == S_OUT_WAIT);
    assign halted    = (r_state == S_HALT);

endmodule
